// File: rtl/candidate_sequencer_pkg.sv
// Shared definitions for the password candidate sequencer.
//   ASCII_A       : ASCII code of the first alphabet letter ('a')
//   ALPHABET_SIZE : letters per character position
//   DIGIT_W       : width of one position counter
//   seq_state_t   : sequencer control states
package pw_pkg;

  localparam logic [7:0]  ASCII_A       = 8'h61;
  localparam int unsigned ALPHABET_SIZE = 26;
  localparam int unsigned DIGIT_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FOUND
  } seq_state_t;

endpackage

// File: rtl/candidate_sequencer_if.sv
// Candidate / match bus between the sequencer and the hash comparator.
//   cand_valid : sequencer presents a candidate
//   cand_ready : comparator accepts the candidate
//   candidate  : ASCII candidate, [7:0] = position 0
//   match      : comparator hit pulse
//   match_cand : candidate that hit, qualified by match
// Modports: master = sequencer side, slave = comparator side.
interface candidate_sequencer_if #(
  parameter int unsigned NUM_CHARS = 4
) ();

  logic                   cand_valid;
  logic                   cand_ready;
  logic [8*NUM_CHARS-1:0] candidate;
  logic                   match;
  logic [8*NUM_CHARS-1:0] match_cand;

  modport master (
    output cand_valid,
    output candidate,
    input  cand_ready,
    input  match,
    input  match_cand
  );

  modport slave (
    input  cand_valid,
    input  candidate,
    output cand_ready,
    output match,
    output match_cand
  );

endinterface

// File: rtl/candidate_sequencer_char_digit.sv
// One odometer position (combinational next-value logic).
//   digit_in  : current registered value of this position
//   load      : load load_val (start of a search)
//   load_val  : value loaded on start
//   step      : advance this position by inc
//   inc       : stride for this position
//   wrap_val  : value taken when the sum reaches the alphabet size
//   digit     : next value of this position
//   carry_out : step wrapped; advance the next position
//   ascii     : ASCII letter for the next value
module char_digit
  import pw_pkg::*;
#(
  parameter int unsigned ALPHABET = ALPHABET_SIZE
) (
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               step,
  input  logic [2:0]         inc,
  input  logic [DIGIT_W-1:0] wrap_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out,
  output logic [7:0]         ascii
);

  localparam logic [DIGIT_W:0] LIMIT = (DIGIT_W + 1)'(ALPHABET);

  // One bit wider than the digit so 25+7 cannot alias back below LIMIT.
  logic [DIGIT_W:0] sum;

  always_comb begin
    sum       = {1'b0, digit_in} + {3'b000, inc};
    digit     = digit_in;
    carry_out = 1'b0;
    if (load) begin
      digit = load_val;
    end else if (step) begin
      if (sum < LIMIT) begin
        digit = sum[DIGIT_W-1:0];
      end else begin
        digit     = wrap_val;
        carry_out = 1'b1;
      end
    end
  end

  assign ascii = ASCII_A + {3'b000, digit};

endmodule

// File: rtl/candidate_sequencer.sv
// Password candidate sequencer: walks NUM_CHARS letter positions as an
// odometer and offers each ASCII candidate to the hash comparator.
// Position 0 starts at start_pos and strides by increment so several cores
// can split the keyspace; higher positions step by one on carry.
//   clock, reset : system clock, synchronous active-high reset
//   start        : begin a search (accepted in IDLE, DONE, FOUND)
//   start_pos    : position-0 start offset (>= ALPHABET means 0)
//   increment    : position-0 stride (0 means 1)
//   cmp_bus      : candidate/match bus to the comparator (master side)
//   found_pw     : latched matching password
//   busy         : search running
//   done         : search ended (match or keyspace exhausted)
//   found        : search ended on a match
//   cand_count   : handshake counter, saturating (only with CANDIDATE_COUNT_EN)
// Optional feature macro: CANDIDATE_COUNT_EN
module candidate_sequencer
  import pw_pkg::*;
#(
  parameter int unsigned NUM_CHARS = 4,
  parameter int unsigned ALPHABET  = ALPHABET_SIZE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             start_pos,
  input  logic [2:0]             increment,
  candidate_sequencer_if.master  cmp_bus,
  output logic [8*NUM_CHARS-1:0] found_pw,
  output logic                   busy,
  output logic                   done,
  output logic                   found
`ifdef CANDIDATE_COUNT_EN
  ,
  output logic [31:0]            cand_count
`endif
);

  localparam int unsigned DW = NUM_CHARS * DIGIT_W;

  seq_state_t             state_q, state_d;
  logic [DIGIT_W-1:0]     start_pos_q, start_pos_d;
  logic [2:0]             inc_q, inc_d;
  logic [DW-1:0]          digits_q, digits_d;
  logic [8*NUM_CHARS-1:0] candidate_q, candidate_d;
  logic [8*NUM_CHARS-1:0] found_pw_q, found_pw_d;

  logic                   load;
  logic                   handshake;
  logic                   advance;
  logic                   exhaust;
  logic [DIGIT_W-1:0]     sp_clamped;
  logic [DW-1:0]          digit_next;
  logic [8*NUM_CHARS-1:0] ascii_vec;

  assign load       = start && (state_q != RUN);
  assign handshake  = (state_q == RUN) && cmp_bus.cand_ready;
  // A match in the same cycle as a handshake freezes the digits.
  assign advance    = handshake && !cmp_bus.match;
  assign sp_clamped = (start_pos < 8'(ALPHABET)) ? start_pos[DIGIT_W-1:0] : '0;

  // Odometer chain: position 0 uses the latched stride and wraps to the
  // latched start offset; upper positions step by one and wrap to zero.
  for (genvar i = 0; i < NUM_CHARS; i++) begin : g_pos
    logic               step;
    logic               carry;
    logic [2:0]         inc;
    logic [DIGIT_W-1:0] wrap;
    logic [DIGIT_W-1:0] ld;
    logic [DIGIT_W-1:0] nxt;
    logic [7:0]         asc;

    if (i == 0) begin : g_lsb
      assign step = advance;
      assign inc  = inc_q;
      assign wrap = start_pos_q;
      assign ld   = sp_clamped;
    end else begin : g_upper
      assign step = g_pos[i-1].carry;
      assign inc  = 3'd1;
      assign wrap = '0;
      assign ld   = '0;
    end

    char_digit #(
      .ALPHABET (ALPHABET)
    ) u_digit (
      .digit_in  (digits_q[i*DIGIT_W +: DIGIT_W]),
      .load      (load),
      .load_val  (ld),
      .step      (step),
      .inc       (inc),
      .wrap_val  (wrap),
      .digit     (nxt),
      .carry_out (carry),
      .ascii     (asc)
    );

    assign digit_next[i*DIGIT_W +: DIGIT_W] = nxt;
    assign ascii_vec[8*i +: 8]              = asc;
  end

  assign exhaust = g_pos[NUM_CHARS-1].carry;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (start) state_d = RUN;
      RUN: begin
        if (cmp_bus.match)          state_d = FOUND;
        else if (advance && exhaust) state_d = DONE;
      end
      DONE, FOUND: if (start) state_d = RUN;
      default:     state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmp_bus.cand_valid = (state_q == RUN);
    busy               = (state_q == RUN);
    done               = (state_q == DONE) || (state_q == FOUND);
    found              = (state_q == FOUND);
  end

  // Datapath next values
  always_comb begin
    start_pos_d = start_pos_q;
    inc_d       = inc_q;
    if (load) begin
      start_pos_d = sp_clamped;
      inc_d       = (increment == 3'd0) ? 3'd1 : increment;
    end
    digits_d = digit_next;
    // Candidate is captured from the digits' next values so it lines up
    // with the digit registers in the same cycle.
    candidate_d = candidate_q;
    if (load || (advance && !exhaust)) begin
      candidate_d = ascii_vec;
    end
    found_pw_d = found_pw_q;
    if ((state_q == RUN) && cmp_bus.match) begin
      found_pw_d = cmp_bus.match_cand;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_pos_q <= '0;
      inc_q       <= '0;
      digits_q    <= '0;
      candidate_q <= '0;
      found_pw_q  <= '0;
    end else begin
      start_pos_q <= start_pos_d;
      inc_q       <= inc_d;
      digits_q    <= digits_d;
      candidate_q <= candidate_d;
      found_pw_q  <= found_pw_d;
    end
  end

  assign cmp_bus.candidate = candidate_q;
  assign found_pw          = found_pw_q;

`ifdef CANDIDATE_COUNT_EN
  logic [31:0] cand_count_q, cand_count_d;

  always_comb begin
    cand_count_d = cand_count_q;
    if (load) begin
      cand_count_d = '0;
    end else if (handshake && (cand_count_q != '1)) begin
      cand_count_d = cand_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cand_count_q <= '0;
    end else begin
      cand_count_q <= cand_count_d;
    end
  end

  assign cand_count = cand_count_q;
`endif

endmodule

// File: tb/tb_candidate_sequencer.sv
// Directed self-checking bench for candidate_sequencer with NUM_CHARS=2.
module tb_candidate_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  start_pos;
  logic [2:0]  increment;
  logic [15:0] found_pw;
  logic        busy;
  logic        done;
  logic        found;

  int unsigned chk_cnt;
  int unsigned pass_cnt;
  int unsigned fail_cnt;

  candidate_sequencer_if #(.NUM_CHARS(2)) bus ();

  candidate_sequencer #(
    .NUM_CHARS (2),
    .ALPHABET  (26)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .start_pos (start_pos),
    .increment (increment),
    .cmp_bus   (bus),
    .found_pw  (found_pw),
    .busy      (busy),
    .done      (done),
    .found     (found)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    fail_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    start_pos = 8'd0;
    increment = 3'd1;
    bus.cand_ready = 1'b0;
    bus.match = 1'b0;
    bus.match_cand = 16'h0000;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_valid", 32'(bus.cand_valid), 32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_done",  32'(done),           32'd0);
    chk("rst_found", 32'(found),          32'd0);
    chk("rst_cand",  32'(bus.candidate),  32'h0000);
    chk("rst_fpw",   32'(found_pw),       32'h0000);

    // Test 1: start at 'aa', stride 1
    start = 1'b1; start_pos = 8'd0; increment = 3'd1; bus.cand_ready = 1'b1;
    step();
    start = 1'b0;
    chk("t1_valid", 32'(bus.cand_valid), 32'd1);
    chk("t1_busy",  32'(busy),           32'd1);
    chk("t1_c0",    32'(bus.candidate),  32'h6161);
    step();
    chk("t1_c1",    32'(bus.candidate),  32'h6162);
    step();
    chk("t1_c2",    32'(bus.candidate),  32'h6163);

    // Test 2: reach 'a','z' then carry into position 1
    for (int i = 0; i < 23; i++) step();
    chk("t2_az",    32'(bus.candidate),  32'h617A);
    step();
    chk("t2_carry", 32'(bus.candidate),  32'h6261);

    // start while running is ignored; run keeps advancing
    start = 1'b1; start_pos = 8'd3;
    step();
    start = 1'b0;
    chk("ign_start", 32'(bus.candidate), 32'h6262);

    // Test 3: back-pressure holds the candidate
    bus.cand_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", 32'(bus.cand_valid), 32'd1);
      chk("t3_hold",  32'(bus.candidate),  32'h6262);
    end
    bus.cand_ready = 1'b1;
    step();
    chk("t3_resume", 32'(bus.candidate), 32'h6263);

    // Test 5: match together with a handshake
    bus.match = 1'b1; bus.match_cand = 16'h6364;
    step();
    bus.match = 1'b0;
    chk("t5_found", 32'(found),          32'd1);
    chk("t5_done",  32'(done),           32'd1);
    chk("t5_valid", 32'(bus.cand_valid), 32'd0);
    chk("t5_busy",  32'(busy),           32'd0);
    chk("t5_fpw",   32'(found_pw),       32'h6364);
    chk("t5_noadv", 32'(bus.candidate),  32'h6263);

    // match outside RUN is ignored
    bus.match = 1'b1; bus.match_cand = 16'h1111;
    step();
    bus.match = 1'b0;
    chk("m_ign_fpw", 32'(found_pw), 32'h6364);

    // Restart from FOUND: start_pos 3, stride 2
    start = 1'b1; start_pos = 8'd3; increment = 3'd2; bus.cand_ready = 1'b0;
    step();
    start = 1'b0;
    chk("rs_cand",  32'(bus.candidate), 32'h6164);
    chk("rs_done",  32'(done),          32'd0);
    chk("rs_found", 32'(found),         32'd0);
    bus.cand_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    chk("s2_z",     32'(bus.candidate), 32'h617A);
    step();
    chk("s2_wrap",  32'(bus.candidate), 32'h6264);

    // Test 6: reset mid-run
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_valid", 32'(bus.cand_valid), 32'd0);
    chk("t6_busy",  32'(busy),           32'd0);
    chk("t6_cand",  32'(bus.candidate),  32'h0000);
    chk("t6_fpw",   32'(found_pw),       32'h0000);
    chk("t6_done",  32'(done),           32'd0);

    // Out-of-range start_pos clamps to 0, increment 0 behaves as 1
    start = 1'b1; start_pos = 8'd200; increment = 3'd0;
    step();
    start = 1'b0;
    chk("t6_restart", 32'(bus.candidate), 32'h6161);
    step();
    chk("inc0",       32'(bus.candidate), 32'h6162);

    // Test 4: exhaustion after 676 handshakes
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1; start_pos = 8'd0; increment = 3'd1; bus.cand_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 675; i++) step();
    chk("t4_last",  32'(bus.candidate),  32'h7A7A);
    chk("t4_lastv", 32'(bus.cand_valid), 32'd1);
    step();
    chk("t4_done",  32'(done),           32'd1);
    chk("t4_found", 32'(found),          32'd0);
    chk("t4_valid", 32'(bus.cand_valid), 32'd0);
    chk("t4_busy",  32'(busy),           32'd0);
    step();
    chk("t4_stay",  32'(done),           32'd1);

    // Restart from DONE: start_pos 25, stride 7 wraps immediately
    start = 1'b1; start_pos = 8'd25; increment = 3'd7;
    step();
    start = 1'b0;
    chk("d_rs_cand", 32'(bus.candidate), 32'h617A);
    chk("d_rs_done", 32'(done),          32'd0);
    step();
    chk("d_wrap",    32'(bus.candidate), 32'h627A);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
